// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - write-back stage: selects result, holds loads until dhit, drives RF write port
// Optional macro WB_BYPASS_EN adds fwd_valid/fwd_sel/fwd_dat forwarding outputs.
module writeback_stage #(
  parameter int WORD_W = 32,
  parameter int RSEL_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_wen,
  input  logic [RSEL_W-1:0] ex_wsel,
  input  logic [1:0]        ex_src,
  input  logic [WORD_W-1:0] ex_alu,
  input  logic [WORD_W-1:0] ex_pc,
  input  logic [15:0]       ex_imm,
  input  logic              dhit,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              rf_wen,
  output logic [RSEL_W-1:0] rf_wsel,
  output logic [WORD_W-1:0] rf_wdat,
  output logic              busy,
  output logic [CNT_W-1:0]  retire_cnt
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd_valid,
  output logic [RSEL_W-1:0] fwd_sel,
  output logic [WORD_W-1:0] fwd_dat
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;
  localparam logic [1:0] SRC_LUI  = 2'b11;

  state_t              r_state;
  state_t              w_next;
  logic                r_wen;
  logic [RSEL_W-1:0]   r_wsel;
  logic [WORD_W-1:0]   r_wdat;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_accept;
  logic [WORD_W-1:0]   w_lui;

  assign w_lui = WORD_W'({ex_imm, 16'h0000});

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    ex_ready = (r_state != S_WAIT_MEM);
    w_accept = ex_valid && ex_ready;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE, S_WRITE: begin
        if (w_accept) w_next = (ex_src == SRC_MEM) ? S_WAIT_MEM : S_WRITE;
        else          w_next = S_IDLE;
      end
      S_WAIT_MEM: if (dhit) w_next = S_WRITE;
      default:    w_next = S_IDLE;
    endcase
    // r0 is hardwired: the descriptor still retires, but nothing is written
    rf_wen = (r_state == S_WRITE) && r_wen && (r_wsel != '0);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wen  <= 1'b0;
      r_wsel <= '0;
      r_wdat <= '0;
    end else if (w_accept) begin
      r_wen  <= ex_wen;
      r_wsel <= ex_wsel;
      case (ex_src)
        SRC_ALU:  r_wdat <= ex_alu;
        SRC_LINK: r_wdat <= ex_pc + WORD_W'(4);
        SRC_LUI:  r_wdat <= w_lui;
        default:  r_wdat <= r_wdat;
      endcase
    end else if ((r_state == S_WAIT_MEM) && dhit) begin
      r_wdat <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                  r_cnt <= '0;
    else if (r_state == S_WRITE) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign rf_wsel    = r_wsel;
  assign rf_wdat    = r_wdat;
  assign retire_cnt = r_cnt;

`ifdef WB_BYPASS_EN
  assign fwd_valid = rf_wen;
  assign fwd_sel   = r_wsel;
  assign fwd_dat   = r_wdat;
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final datapath stage. Accepts one result descriptor per handshake from the execute/memory side, selects the write-back value, and drives the register file write port (WEN, wsel, wdat).
- Holds load results until the data cache reports dhit, so the register file is only ever written with final data.
- Keeps a retired-write counter for bench and debug visibility.

Parameters:
- WORD_W, 32, data and PC width in bits.
- RSEL_W, 5, register select width.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- ex_valid  in  1  descriptor valid
- ex_ready  out  1  stage can accept a descriptor this cycle
- ex_wen  in  1  instruction writes a register
- ex_wsel  in  RSEL_W  destination register
- ex_src  in  2  value source: 00 ALU, 01 MEM, 10 LINK, 11 LUI
- ex_alu  in  WORD_W  ALU result
- ex_pc  in  WORD_W  PC of the instruction
- ex_imm  in  16  immediate field
- dhit  in  1  data cache load complete
- mem_rdata  in  WORD_W  load data, valid when dhit=1
- rf_wen  out  1  register file write enable
- rf_wsel  out  RSEL_W  register file write select
- rf_wdat  out  WORD_W  register file write data
- busy  out  1  state is not IDLE
- retire_cnt  out  CNT_W  count of completed descriptors

Behaviour:
- States: IDLE, WAIT_MEM, WRITE. Reset forces IDLE and clears all internal registers, so rf_wen=0, rf_wsel=0, rf_wdat=0, busy=0 and retire_cnt=0 while nrst=0.
- ex_ready=1 in IDLE and WRITE; ex_ready=0 in WAIT_MEM.
- Accept condition: ex_valid && ex_ready. On accept, latch ex_wen and ex_wsel.
  - src ALU: value = ex_alu; next state WRITE.
  - src LINK: value = ex_pc + 4, modulo 2^WORD_W (0xFFFFFFFC+4 = 0); next state WRITE.
  - src LUI: value = {ex_imm, 16'h0}; next state WRITE.
  - src MEM: next state WAIT_MEM; data register unchanged.
- WAIT_MEM: on dhit, latch mem_rdata and go to WRITE. Without dhit, hold indefinitely; ex_valid is ignored.
- WRITE lasts exactly one cycle.
  - rf_wen = latched wen && (latched wsel != 0).
  - rf_wsel and rf_wdat come from the latched registers only, never combinationally from inputs.
  - retire_cnt increments by 1 at the end of WRITE and wraps at 2^CNT_W. It counts descriptors with wen=0 or wsel=0 too.
  - From WRITE, a same-cycle accept goes straight to WRITE (non-MEM) or WAIT_MEM (MEM); with no accept, next state is IDLE.
- rf_wen=0 in IDLE and WAIT_MEM. rf_wsel and rf_wdat hold their last values.
- Latency and throughput:
  - Non-MEM: accepted at edge N, rf_wen high in cycle N+1, register file updated at edge N+2. Sustained rate is 1 per cycle.
  - MEM: dhit seen in cycle M gives rf_wen in cycle M+1.
- ex_ready low when ex_valid=1: the descriptor is not consumed; the upstream holds it.
- Reset asserted mid-operation (WAIT_MEM or WRITE): the in-flight write is dropped, with no rf_wen pulse after release.
- busy = (state != IDLE).

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: adds outputs fwd_valid (1), fwd_sel (RSEL_W) and fwd_dat (WORD_W).
  - fwd_valid = 1 exactly when rf_wen=1.
  - fwd_sel = rf_wsel, fwd_dat = rf_wdat, so decode can forward a value in the same cycle it is written.
  - In WAIT_MEM, fwd_valid=0.
- Undefined: these ports do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset, then nrst released with idle inputs -> rf_wen=0, busy=0, retire_cnt=0, ex_ready=1.
- ALU descriptor, wsel=5, alu=0xDEADBEEF, accepted at edge N -> cycle N+1 shows rf_wen=1, wsel=5, wdat=0xDEADBEEF; retire_cnt=1 after the next edge.
- Back-to-back ALU to r1=0x11 and r2=0x22 on consecutive cycles -> two consecutive single-cycle rf_wen pulses in order, with no bubble.
- MEM descriptor to r8, dhit held low 3 cycles then high with rdata=0xCAFEF00D -> ex_ready=0 for those 3 cycles; rf_wen one cycle after dhit with wdat=0xCAFEF00D.
- LINK with pc=0x00400010, wsel=31 -> wdat=0x00400014. LUI with imm=0x1234 -> wdat=0x12340000. Descriptor with wsel=0, wen=1 -> rf_wen stays 0 and retire_cnt still increments.
- nrst asserted while in WAIT_MEM, then dhit=1 after release -> no rf_wen pulse, state IDLE, retire_cnt=0.
